// File: rtl/soma_arb_pkg.sv
// soma_arb_pkg: shared widths, operand/result types and the round-robin pick helper
package soma_arb_pkg;
  localparam int DW = 8;
  typedef logic [DW-1:0] operand_t;
  typedef logic [DW:0] result_t;
  function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int n);
    logic [2:0] g;
    logic f;
    int idx;
    g = '0;
    f = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !f && valid[idx]) begin
        g = 3'(idx);
        f = 1'b1;
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/soma_tag_fifo.sv
// soma_tag_fifo: in-order requester-id fifo tracking issued-but-unreturned operations
module soma_tag_fifo import soma_arb_pkg::*; #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/soma_rr_arbiter.sv
// soma_rr_arbiter: round-robin share of one in-order adder with tag-fifo response routing
module soma_rr_arbiter import soma_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*DW-1:0] req_data1_i,
  input  logic [NUM_REQ*DW-1:0] req_data2_i,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output logic [DW:0]           rsp_data_o,
  output logic                  add_valid_o,
  input  logic                  add_ready_i,
  output logic [DW-1:0]         add_data1_o,
  output logic [DW-1:0]         add_data2_o,
  input  logic                  add_valid_i,
  output logic                  add_ready_o,
  input  logic [DW:0]           add_data_i
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [IW-1:0] rr_ptr, locked_id, grant, head;
  logic [2:0] scan;
  logic lock, full, empty, push, pop, rsp_any;
  logic [$clog2(MAX_OUT):0] cnt;
  assign scan = rr_pick(8'(req_valid_i), 3'(rr_ptr), NUM_REQ);
  assign grant = lock ? locked_id : IW'(scan);
  assign add_valid_o = (lock | (|req_valid_i)) & ~full;
  assign add_data1_o = add_valid_o ? req_data1_i[grant*DW +: DW] : '0;
  assign add_data2_o = add_valid_o ? req_data2_i[grant*DW +: DW] : '0;
  assign push = add_valid_o & add_ready_i;
  assign req_ready_o = push ? NUM_REQ'(1) << grant : '0;
  assign rsp_any = add_valid_i & ~empty;
  assign rsp_valid_o = rsp_any ? NUM_REQ'(1) << head : '0;
  assign rsp_data_o = rsp_any ? add_data_i : '0;
  assign add_ready_o = ~empty & rsp_ready_i[head];
  assign pop = add_valid_i & add_ready_o;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr <= '0;
      lock <= 1'b0;
      locked_id <= '0;
    end else if (push) begin
      rr_ptr <= grant == IW'(NUM_REQ-1) ? '0 : grant + 1'b1;
      lock <= 1'b0;
    end else if (add_valid_o) begin
      lock <= 1'b1;
      locked_id <= grant;
    end
  end
  soma_tag_fifo #(.WIDTH(IW), .DEPTH(MAX_OUT)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .push(push),
    .pop(pop),
    .din(grant),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(cnt)
  );
endmodule

// File: tb/tb_soma_rr_arbiter.sv
// tb_soma_rr_arbiter: directed self-checking bench for the round-robin adder arbiter
module tb_soma_rr_arbiter;
  logic clk = 1'b0;
  logic rstn;
  logic [3:0] rvalid, rready_o, rsp_v, rrdy;
  logic [31:0] d1, d2;
  logic [8:0] rsp_d, adata_in;
  logic avalid_o, aready_i, avalid_i, aready_o;
  logic [7:0] ad1, ad2;
  int checks = 0;
  int errors = 0;
  logic [8:0] sums [4];
  soma_rr_arbiter #(.NUM_REQ(4), .MAX_OUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid_i(rvalid), .req_ready_o(rready_o),
    .req_data1_i(d1), .req_data2_i(d2),
    .rsp_valid_o(rsp_v), .rsp_ready_i(rrdy), .rsp_data_o(rsp_d),
    .add_valid_o(avalid_o), .add_ready_i(aready_i),
    .add_data1_o(ad1), .add_data2_o(ad2),
    .add_valid_i(avalid_i), .add_ready_o(aready_o), .add_data_i(adata_in)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (rstn && dut.lock && !rvalid[dut.locked_id]) begin
      errors++;
      $error("FAIL protocol: locked requester %0d dropped valid", dut.locked_id);
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    rstn = 1'b0; rvalid = '0; d1 = '0; d2 = '0; rrdy = 4'hF;
    aready_i = 1'b0; avalid_i = 1'b0; adata_in = '0;
    tick; tick;
    rstn = 1'b1;
    #1;
    chk("rst_add_valid", 32'(avalid_o), 0);
    chk("rst_req_ready", 32'(rready_o), 0);
    chk("rst_rsp_valid", 32'(rsp_v), 0);
    chk("rst_add_ready", 32'(aready_o), 0);
    chk("rst_add_data1", 32'(ad1), 0);
    chk("rst_rsp_data", 32'(rsp_d), 0);
    // test 1: single op from requester 2, 3-cycle adder latency
    d1[23:16] = 8'hFF; d2[23:16] = 8'h01; rvalid = 4'b0100; aready_i = 1'b1;
    #1;
    chk("t1_req_ready", 32'(rready_o), 32'h4);
    chk("t1_add_d1", 32'(ad1), 32'hFF);
    chk("t1_add_d2", 32'(ad2), 32'h01);
    tick;
    rvalid = '0;
    #1;
    chk("t1_add_ready_out", 32'(aready_o), 1);
    chk("t1_rsp_idle", 32'(rsp_v), 0);
    tick; tick;
    avalid_i = 1'b1; adata_in = 9'h100;
    #1;
    chk("t1_rsp_valid", 32'(rsp_v), 32'h4);
    chk("t1_rsp_data", 32'(rsp_d), 32'h100);
    tick;
    avalid_i = 1'b0;
    #1;
    chk("t1_empty", 32'(aready_o), 0);
    // test 2: all valid, round robin 0,1,2,3,0 with 1-cycle returns
    rstn = 1'b0; tick; rstn = 1'b1;
    d1 = 32'hF0_80_40_10; d2 = 32'h20_80_C0_20;
    sums[0] = 9'h030; sums[1] = 9'h100; sums[2] = 9'h100; sums[3] = 9'h110;
    rvalid = 4'hF; aready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) rvalid = '0;
      avalid_i = c > 0;
      adata_in = c > 0 ? sums[(c-1)%4] : '0;
      #1;
      if (c < 5) begin
        chk("t2_req_ready", 32'(rready_o), 32'(4'b0001 << (c % 4)));
        chk("t2_add_d1", 32'(ad1), 32'(d1[(c%4)*8 +: 8]));
      end
      if (c > 0) begin
        chk("t2_rsp_valid", 32'(rsp_v), 32'(4'b0001 << ((c-1) % 4)));
        chk("t2_rsp_data", 32'(rsp_d), 32'(sums[(c-1)%4]));
      end
      tick;
    end
    avalid_i = 1'b0;
    #1;
    chk("t2_empty", 32'(aready_o), 0);
    // test 3: adder stalls 5 cycles with requesters 1 and 3 valid
    rvalid = 4'b1010; aready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_hold_d1", 32'(ad1), 32'h40);
      chk("t3_hold_d2", 32'(ad2), 32'hC0);
      chk("t3_no_ready", 32'(rready_o), 0);
      tick;
    end
    aready_i = 1'b1;
    #1;
    chk("t3_issue1", 32'(rready_o), 32'h2);
    tick;
    #1;
    chk("t3_issue3", 32'(rready_o), 32'h8);
    chk("t3_d1_req3", 32'(ad1), 32'hF0);
    tick;
    rvalid = '0; avalid_i = 1'b1; adata_in = sums[1];
    #1;
    chk("t3_rsp1", 32'(rsp_v), 32'h2);
    tick;
    adata_in = sums[3];
    #1;
    chk("t3_rsp3", 32'(rsp_v), 32'h8);
    tick;
    avalid_i = 1'b0;
    // test 4: fill to MAX_OUT with no returns
    rvalid = 4'hF;
    tick; tick; tick; tick;
    #1;
    chk("t4_full_valid", 32'(avalid_o), 0);
    chk("t4_full_ready", 32'(rready_o), 0);
    chk("t4_full_d1", 32'(ad1), 0);
    avalid_i = 1'b1; adata_in = sums[0];
    #1;
    chk("t4_ret_rsp", 32'(rsp_v), 32'h1);
    chk("t4_ret_ready", 32'(aready_o), 1);
    chk("t4_still_full", 32'(avalid_o), 0);
    tick;
    adata_in = sums[1];
    #1;
    chk("t4_reissue", 32'(rready_o), 32'h1);
    chk("t4_rsp1", 32'(rsp_v), 32'h2);
    chk("t4_rsp1_data", 32'(rsp_d), 32'h100);
    tick;
    rvalid = '0; avalid_i = 1'b0;
    #1;
    chk("t4_idle", 32'(avalid_o), 0);
    // test 5: head requester not ready holds the result
    avalid_i = 1'b1; adata_in = sums[2]; rrdy = 4'b1011;
    #1;
    chk("t5_blocked", 32'(aready_o), 0);
    chk("t5_rsp_shown", 32'(rsp_v), 32'h4);
    tick;
    #1;
    chk("t5_still_blocked", 32'(aready_o), 0);
    chk("t5_still_head", 32'(rsp_v), 32'h4);
    rrdy = 4'hF;
    #1;
    chk("t5_release", 32'(aready_o), 1);
    chk("t5_data", 32'(rsp_d), 32'h100);
    tick;
    adata_in = sums[3];
    #1;
    chk("t5_next3", 32'(rsp_v), 32'h8);
    chk("t5_next3_data", 32'(rsp_d), 32'h110);
    tick;
    adata_in = sums[0];
    #1;
    chk("t5_next0", 32'(rsp_v), 32'h1);
    tick;
    avalid_i = 1'b0;
    #1;
    chk("t5_empty", 32'(aready_o), 0);
    // test 6: reset with 2 tags outstanding
    rvalid = 4'b0011;
    #1;
    chk("t6_issue1", 32'(rready_o), 32'h2);
    tick;
    #1;
    chk("t6_issue0", 32'(rready_o), 32'h1);
    tick;
    rvalid = '0;
    rstn = 1'b0; tick; rstn = 1'b1;
    #1;
    chk("t6_add_valid", 32'(avalid_o), 0);
    chk("t6_add_ready", 32'(aready_o), 0);
    chk("t6_rsp_valid", 32'(rsp_v), 0);
    avalid_i = 1'b1; adata_in = 9'h055;
    #1;
    chk("t6_late_rejected", 32'(aready_o), 0);
    chk("t6_late_no_rsp", 32'(rsp_v), 0);
    tick;
    avalid_i = 1'b0; rvalid = 4'b0001;
    #1;
    chk("t6_fresh_ready", 32'(rready_o), 32'h1);
    chk("t6_fresh_d1", 32'(ad1), 32'h10);
    tick;
    rvalid = '0;
    #1;
    chk("t6_fresh_outstanding", 32'(aready_o), 1);
    avalid_i = 1'b1; adata_in = sums[0];
    #1;
    chk("t6_fresh_rsp", 32'(rsp_v), 32'h1);
    chk("t6_fresh_data", 32'(rsp_d), 32'h030);
    tick;
    avalid_i = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
